// File: rtl/bp_update_sched_pkg.sv
// rtl/bp_update_sched_pkg.sv - shared constants and helpers for the branch update scheduler
//
// Purpose : retire width, entry packing width and the slot-acceptance helpers
//           used by bp_update_sched and its queue.
// Contents: SCALAR    - retire slots per cycle (enqueue logic assumes exactly 2)
//           entry_w   - packed queue entry width {npc, taken, addr}
//           popcount2 - number of valid retire slots
//           accept_cnt- slots that fit given the free space this cycle
package bp_update_sched_pkg;

  localparam int SCALAR = 2;

  function automatic int entry_w(input int pc_w);
    return 2 * pc_w + 1;
  endfunction

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

  // Slots are taken in program order; anything beyond the free space is dropped.
  function automatic logic [1:0] accept_cnt(input logic [1:0] n_valid,
                                            input logic       free_ge1,
                                            input logic       free_ge2);
    if (free_ge2) begin
      return n_valid;
    end else if (free_ge1) begin
      return (n_valid != 2'd0) ? 2'd1 : 2'd0;
    end else begin
      return 2'd0;
    end
  endfunction

endpackage

// File: rtl/bp_update_sched_fifo_2w1r.sv
// rtl/bp_update_sched_fifo_2w1r.sv - circular queue with two writes and one read per cycle
//
// Purpose : storage plus head/tail/count for the branch update queue. Writes
//           are pre-compacted by the caller: d0 lands at tail, d1 at tail+1.
// Ports   : clk, reset      - clock, async active-high reset (pointers/count only)
//           i_push_cnt      - entries to write this cycle (0..2)
//           i_push_d0/d1    - compacted write data, d0 older
//           i_pop           - consume the head entry (ignored when empty)
//           o_head          - head entry (show-ahead, not gated)
//           o_count         - occupancy
module bp_update_sched_fifo_2w1r #(
  parameter int DEPTH = 4,
  parameter int W     = 129,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    i_push_cnt,
  input  logic [W-1:0]  i_push_d0,
  input  logic [W-1:0]  i_push_d1,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic [AW-1:0] w_tail_p1;

  // An empty queue never pops, whatever the consumer says.
  assign w_pop     = i_pop && (r_count != '0);
  assign w_tail_p1 = r_tail + AW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + AW'(i_push_cnt);
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      r_count <= r_count + CW'(i_push_cnt) - CW'(w_pop);
    end
  end

  // Entry storage is deliberately left unreset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (i_push_cnt != 2'd0) begin
      r_mem[r_tail] <= i_push_d0;
    end
    if (i_push_cnt == 2'd2) begin
      r_mem[w_tail_p1] <= i_push_d1;
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/bp_update_sched.sv
// rtl/bp_update_sched.sv - schedules 2-wide retired branch updates into a 1-wide predictor port
//
// Purpose : buffers up to two retired branches per cycle and drains one per
//           cycle toward the branch predictor in program order.
// Ports   : clk, reset               - clock, async active-high reset
//           rob_br_en[1:0]           - per-slot retire valid, bit0 older
//           rob_npc/rob_taken_addr   - per-slot NPC / target, slot i at [i*PC_W +: PC_W]
//           rob_taken[1:0]           - per-slot resolved direction
//           rob_stall                - ROB must not retire branches this cycle
//           bp_wr_en/ready           - head valid / predictor accepts
//           bp_wr_npc/taken/addr     - head entry fields (0 when empty)
//           q_count                  - occupancy
//           overflow                 - sticky: a valid slot was dropped
module bp_update_sched
  import bp_update_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64,
  localparam int CW   = $clog2(DEPTH) + 1,
  localparam int EW   = 2 * PC_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SCALAR-1:0]      rob_br_en,
  input  logic [SCALAR*PC_W-1:0] rob_npc,
  input  logic [SCALAR-1:0]      rob_taken,
  input  logic [SCALAR*PC_W-1:0] rob_taken_addr,
  output logic                   rob_stall,
  output logic                   bp_wr_en,
  input  logic                   bp_wr_ready,
  output logic [PC_W-1:0]        bp_wr_npc,
  output logic                   bp_wr_taken,
  output logic [PC_W-1:0]        bp_wr_addr,
  output logic [CW-1:0]          q_count,
  output logic                   overflow
);

  logic [EW-1:0] w_slot0;
  logic [EW-1:0] w_slot1;
  logic [EW-1:0] w_d0;
  logic [EW-1:0] w_head;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_free;
  logic [1:0]    w_n_valid;
  logic [1:0]    w_acc;
  logic          w_pop;
  logic          w_drop;
  logic          r_overflow;

  assign w_slot0 = {rob_npc[0 +: PC_W],    rob_taken[0], rob_taken_addr[0 +: PC_W]};
  assign w_slot1 = {rob_npc[PC_W +: PC_W], rob_taken[1], rob_taken_addr[PC_W +: PC_W]};

  assign bp_wr_en = (w_count != '0);
  assign w_pop    = bp_wr_en && bp_wr_ready;

  // A same-cycle pop frees a slot for this cycle's enqueue.
  assign w_free    = CW'(DEPTH) - w_count + CW'(w_pop);
  assign w_n_valid = popcount2(rob_br_en);
  assign w_acc     = accept_cnt(w_n_valid, w_free != '0, w_free >= CW'(2));
  assign w_drop    = (w_acc != w_n_valid);

  // Compact valid slots so the oldest accepted one always lands at tail.
  // d1 is only used when both slots are accepted, so it is always slot1.
  assign w_d0 = rob_br_en[0] ? w_slot0 : w_slot1;

  bp_update_sched_fifo_2w1r #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push_cnt (w_acc),
    .i_push_d0  (w_d0),
    .i_push_d1  (w_slot1),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Stall looks only at registered occupancy so bp_wr_ready never reaches the ROB.
  assign rob_stall = (CW'(DEPTH) - w_count) < CW'(2);

  // Storage is not cleared by reset, so the head fields are gated by validity.
  assign bp_wr_npc   = bp_wr_en ? w_head[EW-1 -: PC_W] : '0;
  assign bp_wr_taken = bp_wr_en ? w_head[PC_W]         : 1'b0;
  assign bp_wr_addr  = bp_wr_en ? w_head[PC_W-1:0]     : '0;

  assign q_count  = w_count;
  assign overflow = r_overflow;

endmodule
